// File: rtl/ascii_dec_to_hex_core.sv
// ascii_dec_to_hex_core
// Accumulates one ASCII decimal number (delimited by last_i) into a binary
// value, then emits it as uppercase ASCII hex with leading zeros suppressed.
// Invalid characters and overflow are tracked sticky and reported per number.
module ascii_dec_to_hex_core #(
  parameter int BIN_WIDTH  = 32,
  parameter int HEX_DIGITS = BIN_WIDTH / 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ascii_i,
  input  logic       valid_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic [7:0] hex_o,
  output logic       hex_valid_o,
  output logic       hex_last_o,
  input  logic       hex_ready_i,
  output logic       done_o,
  output logic       err_o,
  output logic       ovf_o
);

  // Never walk past the nibbles the accumulator actually has.
  localparam int NIB_N = (HEX_DIGITS < BIN_WIDTH / 4) ? HEX_DIGITS : BIN_WIDTH / 4;
  localparam int PTR_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
  localparam int EXT_W = BIN_WIDTH + 4;

  typedef enum logic [1:0] {
    S_ACCUM,
    S_PREP,
    S_EMIT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [BIN_WIDTH-1:0]   r_acc;
  logic [PTR_W-1:0]       r_ptr;
  logic                   r_err;
  logic                   r_ovf;
  logic                   r_err_o;
  logic                   r_ovf_o;
  logic                   r_done;

  logic                   w_ready;
  logic                   w_hex_valid;
  logic                   w_accept;
  logic                   w_xfer;
  logic                   w_ptr_zero;
  logic                   w_final;
  logic                   w_is_digit;
  logic [EXT_W-1:0]       w_cand;
  logic                   w_cand_ovf;
  logic [PTR_W-1:0]       w_msb_idx;
  logic [3:0]             w_nib;
  logic [7:0]             w_hex_char;

  assign w_ptr_zero = (r_ptr == '0);
  assign w_accept   = valid_i && w_ready;
  assign w_xfer     = w_hex_valid && hex_ready_i;
  assign w_final    = w_xfer && w_ptr_zero;

  // Decimal step: acc*10 + digit at 4 extra bits so any overflow lands in the top nibble.
  assign w_is_digit = (ascii_i >= 8'h30) && (ascii_i <= 8'h39);
  assign w_cand     = ({4'd0, r_acc} * EXT_W'(10)) + EXT_W'(ascii_i[3:0]);
  assign w_cand_ovf = |w_cand[EXT_W-1 -: 4];

  // Index of the most significant nonzero nibble; 0 when the value is 0.
  always_comb begin
    w_msb_idx = '0;
    for (int i = 0; i < NIB_N; i++) begin
      if (r_acc[i*4 +: 4] != 4'd0) w_msb_idx = PTR_W'(i);
    end
  end

  // Nibble currently addressed by the emit pointer.
  always_comb begin
    w_nib = 4'd0;
    for (int i = 0; i < NIB_N; i++) begin
      if (r_ptr == PTR_W'(i)) w_nib = r_acc[i*4 +: 4];
    end
  end

  // Nibble to ASCII: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
  assign w_hex_char = (w_nib < 4'd10) ? (8'h30 + {4'd0, w_nib}) : (8'h37 + {4'd0, w_nib});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) r_state <= S_ACCUM;
    else        r_state <= w_state_next;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_hex_valid  = 1'b0;
    unique case (r_state)
      S_ACCUM: begin
        w_ready = 1'b1;
        if (valid_i && last_i) w_state_next = S_PREP;
      end
      S_PREP:  w_state_next = S_EMIT;
      S_EMIT: begin
        w_hex_valid = 1'b1;
        if (hex_ready_i && w_ptr_zero) w_state_next = S_ACCUM;
      end
      default: w_state_next = S_ACCUM;
    endcase
  end

  // Accumulator, sticky flags, emit pointer and reported status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_err_o <= 1'b0;
      r_ovf_o <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_accept) begin
        if (w_is_digit) begin
          // Once overflowed, the value stays saturated for the rest of the number.
          if (r_ovf || w_cand_ovf) begin
            r_acc <= '1;
            r_ovf <= 1'b1;
          end else begin
            r_acc <= w_cand[BIN_WIDTH-1:0];
          end
        end else begin
          r_err <= 1'b1;
        end
      end
      if (r_state == S_PREP) begin
        r_ptr   <= w_msb_idx;
        r_err_o <= r_err;
        r_ovf_o <= r_ovf;
      end
      if (w_xfer) begin
        if (w_ptr_zero) begin
          r_acc <= '0;
          r_err <= 1'b0;
          r_ovf <= 1'b0;
        end else begin
          r_ptr <= r_ptr - PTR_W'(1);
        end
      end
    end
  end

  // Character outputs are decoded from held registers, so they cannot move while stalled.
  assign ready_o     = w_ready;
  assign hex_valid_o = w_hex_valid;
  assign hex_o       = w_hex_valid ? w_hex_char : 8'h00;
  assign hex_last_o  = w_hex_valid && w_ptr_zero;
  assign done_o      = r_done;
  assign err_o       = r_err_o;
  assign ovf_o       = r_ovf_o;

endmodule

// File: tb/tb_ascii_dec_to_hex_core.sv
// Self-checking bench for ascii_dec_to_hex_core: directed cases plus random
// numbers, compared against a string/arithmetic model of the conversion.
module tb_ascii_dec_to_hex_core;

  localparam int BW = 32;

  typedef byte unsigned bq_t[$];
  typedef struct {
    byte unsigned ch;
    bit           last;
    bit           err;
    bit           ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ascii_i;
  logic       valid_i;
  logic       last_i;
  logic       ready_o;
  logic [7:0] hex_o;
  logic       hex_valid_o;
  logic       hex_last_o;
  logic       hex_ready_i = 1'b1;
  logic       done_o;
  logic       err_o;
  logic       ovf_o;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  int   sink_mode = 0;
  int   pat = 0;
  int   xfer_cnt = 0;
  int   lat_cnt = 0;
  bit   prev_final = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_hex = 8'h00;
  bit   prev_last = 1'b0;

  ascii_dec_to_hex_core #(.BIN_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .ascii_i(ascii_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .hex_o(hex_o), .hex_valid_o(hex_valid_o), .hex_last_o(hex_last_o),
    .hex_ready_i(hex_ready_i), .done_o(done_o), .err_o(err_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: decimal value by plain arithmetic (saturating), then hex text.
  function automatic string model_hex(input bq_t q, output bit err, output bit ovf);
    longint unsigned v  = 0;
    longint unsigned mx = (64'd1 << BW) - 1;
    string h = "";
    int n;
    err = 1'b0;
    ovf = 1'b0;
    foreach (q[i]) begin
      if (q[i] >= 8'h30 && q[i] <= 8'h39) begin
        if (ovf) v = mx;
        else begin
          v = v * 10 + longint'(q[i] - 8'h30);
          if (v > mx) begin
            v   = mx;
            ovf = 1'b1;
          end
        end
      end else begin
        err = 1'b1;
      end
    end
    if (v == 0) return "0";
    while (v != 0) begin
      n = int'(v % 16);
      h = $sformatf("%c%s", (n < 10) ? (8'h30 + n) : (8'h37 + n), h);
      v = v / 16;
    end
    return h;
  endfunction

  task automatic push_expected(input bq_t q);
    bit e, o;
    string h;
    exp_t it;
    h = model_hex(q, e, o);
    for (int i = 0; i < h.len(); i++) begin
      it.ch   = h[i];
      it.last = (i == h.len() - 1);
      it.err  = e;
      it.ovf  = o;
      exp_q.push_back(it);
    end
  endtask

  // Present one byte and hold it until the DUT accepts it.
  task automatic send_byte(input byte unsigned c, input bit l);
    bit acc;
    int guard;
    ascii_i = c;
    valid_i = 1'b1;
    last_i  = l;
    guard   = 0;
    acc     = 1'b0;
    while (!acc && guard < 2000) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic send_number(input bq_t q, input bit gaps);
    push_expected(q);
    foreach (q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        valid_i = 1'b0;
        @(posedge clk);
        #1;
      end
      send_byte(q[i], i == q.size() - 1);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  function automatic bq_t rand_number();
    bq_t q;
    int kind = $urandom_range(0, 7);
    int len;
    byte unsigned b;
    if (kind == 0) begin
      q.push_back(8'h7A);
    end else if (kind == 1) begin
      len = $urandom_range(10, 14);
      for (int i = 0; i < len; i++) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
    end else begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 19) == 0) begin
          b = 8'($urandom_range(0, 255));
          while (b >= 8'h30 && b <= 8'h39) b = 8'($urandom_range(0, 255));
          q.push_back(b);
        end else begin
          q.push_back(8'h30 + 8'($urandom_range(0, 9)));
        end
      end
    end
    return q;
  endfunction

  // Sink: always ready, random, or the 1,0,0 repeating pattern.
  always @(posedge clk) begin
    #1;
    case (sink_mode)
      0: hex_ready_i = 1'b1;
      1: hex_ready_i = ($urandom_range(0, 3) != 0);
      default: begin
        hex_ready_i = (pat == 0);
        pat = (pat + 1) % 3;
      end
    endcase
  end

  // Output checker: every cycle while enabled.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("done_o", done_o, prev_final);
      if (hex_valid_o) check("ready_during_emit", ready_o, 0);
      if (prev_stall) begin
        check("stall_valid", hex_valid_o, 1);
        check("stall_hex", hex_o, prev_hex);
        check("stall_last", hex_last_o, prev_last);
      end
      if (lat_cnt == 1) begin
        check("prep_no_valid", hex_valid_o, 0);
        check("prep_not_ready", ready_o, 0);
        lat_cnt = 2;
      end else if (lat_cnt == 2) begin
        check("latency_valid", hex_valid_o, 1);
        lat_cnt = 0;
      end else if (valid_i && ready_o && last_i) begin
        lat_cnt = 1;
      end
      if (hex_valid_o && hex_ready_i) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_char: got %0h expected none at %0t", hex_o, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("hex_o", hex_o, e.ch);
          check("hex_last_o", hex_last_o, e.last);
          check("err_o", err_o, e.err);
          check("ovf_o", ovf_o, e.ovf);
        end
      end
      prev_final = hex_valid_o && hex_ready_i && hex_last_o;
      prev_stall = hex_valid_o && !hex_ready_i;
      prev_hex   = hex_o;
      prev_last  = hex_last_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hex_o"}, hex_o, 0);
    check({tag, "_hex_valid"}, hex_valid_o, 0);
    check({tag, "_hex_last"}, hex_last_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_ovf"}, ovf_o, 0);
    check({tag, "_ready"}, ready_o, 1);
  endtask

  task automatic pin(input string s, input string hex, input bit e, input bit o);
    bit ge, go;
    string h;
    h = model_hex(s2q(s), ge, go);
    check({"pin_", s}, (h == hex), 1);
    check({"pin_err_", s}, ge, e);
    check({"pin_ovf_", s}, go, o);
  endtask

  initial begin
    int base;
    rst_n   = 1'b0;
    ascii_i = 8'h00;
    valid_i = 1'b0;
    last_i  = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Hand-computed expectations that pin the model.
    pin("255", "FF", 0, 0);
    pin("0", "0", 0, 0);
    pin("000", "0", 0, 0);
    pin("4294967295", "FFFFFFFF", 0, 0);
    pin("4294967296", "FFFFFFFF", 0, 1);
    pin("1x2", "C", 1, 0);
    pin("4096", "1000", 0, 0);
    pin("x", "0", 1, 0);

    // Directed numbers under a continuously ready sink.
    sink_mode = 0;
    send_number(s2q("255"), 0);
    send_number(s2q("0"), 0);
    send_number(s2q("000"), 0);
    send_number(s2q("4294967295"), 0);
    send_number(s2q("4294967296"), 0);
    send_number(s2q("16"), 0);
    send_number(s2q("1x2"), 0);
    send_number(s2q("7"), 0);

    // Stalling sink; the next number's first byte waits with valid_i high.
    sink_mode = 2;
    pat = 0;
    send_number(s2q("4096"), 0);
    send_number(s2q("3"), 0);
    sink_mode = 0;

    // Reset in the middle of emitting "65535".
    base = xfer_cnt;
    send_number(s2q("65535"), 0);
    for (int i = 0; i < 200 && xfer_cnt < base + 2; i++) @(negedge clk);
    check("reset_test_reached", (xfer_cnt >= base + 2), 1);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_done", done_o, 0);
    end
    rst_n = 1'b1;
    exp_q.delete();
    prev_final = 1'b0;
    prev_stall = 1'b0;
    lat_cnt    = 0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    send_number(s2q("10"), 0);

    // Randomized numbers with input gaps and a random sink.
    sink_mode = 1;
    for (int n = 0; n < 60; n++) send_number(rand_number(), 1);

    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && ready_o) break;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ascii_dec_to_hex_core.md
# ascii_dec_to_hex_core

Streaming converter from ASCII decimal digits to ASCII hexadecimal characters, the inverse of the hex-to-decimal path. It accepts one decimal number as a byte stream delimited by `last_i` and accumulates it into a `BIN_WIDTH`-bit binary value, flagging invalid characters and overflow. It then emits the value as uppercase hex ASCII with leading zeros suppressed, on a valid/ready output stream. It sits between the byte front-end (UART/host FIFO) and the character sink.

## Interface
- `BIN_WIDTH`, default 32: accumulator width. Must be a multiple of 4, ≥ 8.
- `HEX_DIGITS`, default `BIN_WIDTH/4`: maximum emitted characters.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ascii_i`  in  8: input character.
- `valid_i`  in  1: `ascii_i` valid.
- `last_i`  in  1: final character of the current number; qualified by `valid_i`.
- `ready_o`  out  1: input accepted when `valid_i && ready_o`.
- `hex_o`  out  8: output ASCII hex character, `'0'`-`'9'` or `'A'`-`'F'`.
- `hex_valid_o`  out  1: `hex_o` valid.
- `hex_last_o`  out  1: final character of the number.
- `hex_ready_i`  in  1: sink ready; transfer occurs on `hex_valid_o && hex_ready_i`.
- `done_o`  out  1: one-cycle pulse when the number is fully emitted.
- `err_o`  out  1: an invalid character was seen in the last completed number.
- `ovf_o`  out  1: the value exceeded `2^BIN_WIDTH-1` in the last completed number.

## Operation
- FSM has three states:
  - ACCUM (reset state): `ready_o` = 1. Exits to PREP on an accepted byte with `last_i`=1.
  - PREP: exactly one cycle. Exits to EMIT.
  - EMIT: exits to ACCUM on the transfer of the character with `hex_last_o`=1.
- `ready_o` is 1 only in ACCUM. It is combinational from state, so it is 1 during and after reset.
- Digit byte (0x30-0x39): candidate = acc·10 + d, computed at `BIN_WIDTH`+4 bits.
  - If the upper 4 bits of the candidate are nonzero, or the sticky overflow flag is already set: acc ← all ones and the sticky overflow flag is set.
  - Otherwise acc ← candidate.
- Any other byte: sets the sticky error flag; acc is unchanged. This also applies when the non-digit byte carries `last_i`.
- In PREP:
  - Compute the index of the most significant nonzero nibble. If acc = 0, the index is 0.
  - Load the nibble pointer with that index.
  - `err_o` ← sticky error flag; `ovf_o` ← sticky overflow flag. Both are held until the next PREP.
- In EMIT:
  - `hex_o` = ASCII of nibble[pointer]: 0-9 → 0x30-0x39, 10-15 → 0x41-0x46.
  - `hex_last_o` = (pointer == 0).
  - On each transfer the pointer decrements.
- An acc of 0, including an empty or all-invalid number, emits the single character `'0'`.
- After the final transfer:
  - `done_o` pulses for one cycle.
  - acc, the sticky error flag and the sticky overflow flag clear.
  - The state returns to ACCUM.
- Output stream rules: once `hex_valid_o` is asserted, `hex_o` and `hex_last_o` hold stable until transfer. `hex_valid_o` never depends combinationally on `hex_ready_i`.

## Timing
- Reset values:
  - `hex_o`, `hex_valid_o`, `hex_last_o`, `done_o`, `err_o`, `ovf_o` = 0.
  - acc, pointer and the sticky flags = 0.
  - State = ACCUM.
- Throughput: one input byte per cycle in ACCUM; one output character per cycle under continuous `hex_ready_i`.
- Latency: last byte accepted at edge k → PREP during cycle k+1 → `hex_valid_o` = 1 after edge k+1.
- `err_o` and `ovf_o` update at the same edge as `hex_valid_o` rises.
- Final transfer at edge m → `done_o` = 1 and `ready_o` = 1 for the cycle after edge m. `done_o` is 0 again after edge m+1.
- Minimum cycles per number = N_in + 1 + N_out.
- `valid_i` during PREP/EMIT is not accepted; the upstream holds its byte.
- Reset asserted mid-accumulation or mid-emission aborts immediately: all outputs go to their reset values, no `done_o` pulse, and a partial number is discarded.

## Test plan
- "255" with `last_i` on '5', `hex_ready_i`=1 → `hex_o` 0x46,0x46 on consecutive cycles, `hex_last_o` on the second; `done_o` one cycle after; `err_o`=0, `ovf_o`=0; `hex_valid_o` rises 2 cycles after the last input accept.
- "0" → single `'0'` (0x30) with `hex_last_o`=1; also "000" → single `'0'`.
- "4294967295" → "FFFFFFFF", `ovf_o`=0. Then "4294967296" → "FFFFFFFF", `ovf_o`=1. Then "16" → "10", with `ovf_o` and `err_o` both 0.
- "1x2" → "C", `err_o`=1; next number "7" → "7", `err_o`=0.
- "4096" with `hex_ready_i` toggling 1,0,0,1,… → "1000" delivered in order, `hex_o` stable while stalled; `valid_i` held high during EMIT is not accepted (`ready_o`=0).
- Reset pulsed during emission of "65535" (after 2 characters) → all outputs 0 immediately, no `done_o`. A following "10" → "A" with clean flags.
